sign_bcd_to_binary: RTL
=======================

# sign_bcd_to_binary

Sequential signed BCD-to-binary converter: accepts a sign flag plus three BCD digits (hundreds, tens, ones) and produces a two's-complement binary value using reverse double dabble, one bit per clock. It is the input-side counterpart of the signed binary-to-BCD/7-segment display path. Decimal operands entered on switches or a keypad pass through this block before reaching the signed ALU. A start/busy/done handshake gives constant-latency conversion and flags invalid digits and out-of-range values.

## Interface
- `W`, default 10: output width in bits; legal range 10..16. Magnitude is computed in 10 bits and sign-extended to `W`.

- `clk` input, 1: single clock, rising-edge active.
- `rst_n` input, 1: synchronous reset, active-low.
- `start` input, 1: request a conversion; sampled only in IDLE.
- `sign` input, 1: 1 = negative operand; captured with `start`.
- `bcd_hundreds` input, 4: hundreds digit; captured with `start`.
- `bcd_tens` input, 4: tens digit; captured with `start`.
- `bcd_ones` input, 4: ones digit; captured with `start`.
- `busy` output, 1: high while a conversion is in progress.
- `done` output, 1: one-cycle pulse when `y`, `err` and `ovf` update.
- `y` output, W: signed result, held until the next `done`.
- `err` output, 1: at least one captured digit was greater than 9.
- `ovf` output, 1: value is outside the range [-512, +511] of the signed 10-bit result.

## Operation
- States:
  - IDLE: `busy` = 0. If `start` = 1, capture `sign` and the 12-bit BCD word {h, t, o}, clear the 10-bit shift accumulator and iteration counter, and go to SHIFT.
  - SHIFT: runs for 10 iterations. Each iteration:
    - shift {bcd, acc} right by 1; the BCD LSB enters the accumulator MSB.
    - then, in each BCD digit that is ≥ 8, subtract 3.
    - After the 10th iteration go to FIX.
  - FIX: apply the sign, check range, register `y`/`err`/`ovf`, pulse `done`, return to IDLE.
- Invalid-digit check happens at capture. Latency is unchanged when a digit is invalid. On `err` = 1: `y` = 0 and `ovf` = 0.
- Range rules, with mag = 0..999:
  - Positive with mag > 511 sets `ovf`.
  - Negative with mag > 512 sets `ovf`.
  - Negative with mag = 512 gives -512 (10'h200) with `ovf` = 0.
  - Negative zero gives `y` = 0.
- The valid result is y = sign ? -mag : mag, sign-extended to `W`.
- `start` while `busy` is ignored and never queued.
- Inputs may change after capture without affecting the conversion in flight.

## Timing
- Reset values: `busy` 0, `done` 0, `y` 0, `err` 0, `ovf` 0; state = IDLE.
- `start` sampled high at edge 0 (in IDLE):
  - `busy` rises after edge 0.
  - SHIFT iterations occur at edges 1..10.
  - FIX at edge 11 updates `y`/`err`/`ovf`, drives `done` = 1 for the cycle following edge 11, and drops `busy`.
- Fixed latency is 11 cycles from the start sample to `done`.
- A new `start` is accepted at edge 12 at the earliest. `start` held high produces back-to-back conversions, one every 12 cycles.
- `rst_n` low at any edge, including mid-conversion, aborts the conversion and restores reset values at that edge. No `done` is produced for the aborted request.
- `done` is never asserted while `rst_n` is low.

## Configuration
- Macro `BCD2BIN_SAT_EN`.
- Defined: an out-of-range valid input saturates `y` to +511 (positive) or -512 (negative), sign-extended to `W`, with `ovf` = 1.
- Undefined: an out-of-range input gives `y` = 0 with `ovf` = 1.
- `err` behaviour is identical in both builds.

## Test plan
- Reset, then `sign` = 0, digits 1/2/3, `start` pulse -> `done` exactly 11 cycles later, `y` = 123, `err` = 0, `ovf` = 0, `busy` high for 11 cycles.
- `sign` = 1, digits 5/1/2 -> `y` = -512 (10'h200), `ovf` = 0. Then `sign` = 1, digits 0/0/0 -> `y` = 0.
- `sign` = 0, digits 5/1/2 and `sign` = 1, digits 9/9/9 -> `ovf` = 1, with:
  - `y` = 0 when the macro is undefined.
  - `y` = +511 and -512 when `BCD2BIN_SAT_EN` is defined.
- `sign` = 0, digits 0/A/3 -> `err` = 1, `y` = 0, `ovf` = 0, same 11-cycle latency.
- `start` re-pulsed at cycle 4 of a conversion with different digits -> ignored; the first result is delivered and only one `done` occurs.
- `rst_n` low at cycle 6 of a conversion of 7/4/2 -> all outputs 0 the next cycle, no `done`. A subsequent `start` with 0/4/2 -> `y` = 42.

Source files
------------

// File: rtl/sign_bcd_to_binary.sv
// Sequential signed 3-digit BCD to two's-complement converter using reverse double dabble.
// Optional macro BCD2BIN_SAT_EN: out-of-range results saturate instead of reading zero.
module sign_bcd_to_binary #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sign,
    input  logic [3:0]   bcd_hundreds,
    input  logic [3:0]   bcd_tens,
    input  logic [3:0]   bcd_ones,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y,
    output logic         err,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

    state_t       state;
    logic [11:0]  bcd_q;
    logic [9:0]   acc_q;
    logic [3:0]   cnt;
    logic         sign_q;
    logic         err_q;

    logic [11:0]  bcd_nxt;
    logic [9:0]   acc_nxt;
    logic [21:0]  shifted;
    logic [W-1:0] mag_w;
    logic [W-1:0] pos_sat;
    logic [W-1:0] neg_sat;
    logic [W-1:0] y_fix;
    logic         ovf_fix;
    logic         range_bad;

    // One reverse double-dabble step: shift right, then correct each digit that reached 8 or more.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        shifted = {bcd_q, acc_q} >> 1;
        bcd_nxt = shifted[21:10];
        acc_nxt = shifted[9:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_nxt[i*4 +: 4] >= 4'd8)
                bcd_nxt[i*4 +: 4] = bcd_nxt[i*4 +: 4] - 4'd3;
        end
    end

    // Sign application and range check on the finished 10-bit magnitude.
    always_comb begin
        mag_w        = '0;
        mag_w[9:0]   = acc_q;
        pos_sat      = '0;
        pos_sat[8:0] = '1;
        neg_sat      = '1;
        neg_sat[8:0] = '0;
        range_bad    = sign_q ? (acc_q > 10'd512) : (acc_q > 10'd511);
        y_fix        = sign_q ? -mag_w : mag_w;
        ovf_fix      = 1'b0;
        if (err_q) begin
            y_fix = '0;
        end else if (range_bad) begin
            ovf_fix = 1'b1;
`ifdef BCD2BIN_SAT_EN
            y_fix   = sign_q ? neg_sat : pos_sat;
`else
            y_fix   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            err    <= 1'b0;
            ovf    <= 1'b0;
            bcd_q  <= '0;
            acc_q  <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_q  <= {bcd_hundreds, bcd_tens, bcd_ones};
                        sign_q <= sign;
                        err_q  <= (bcd_hundreds > 4'd9) || (bcd_tens > 4'd9) || (bcd_ones > 4'd9);
                        acc_q  <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_nxt;
                    acc_q <= acc_nxt;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd9)
                        state <= FIX;
                end
                FIX: begin
                    y     <= y_fix;
                    err   <= err_q;
                    ovf   <= ovf_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
